// File: rtl/sbox_bank_if.sv
// Data handshake and table-load signals of the sbox_bank substitution unit.
// The master side drives beats and table writes; the slave side is the unit itself.
interface sbox_bank_if #(
    parameter int unsigned LANES = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4*LANES-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [4*LANES-1:0]   out_data;
    logic                 ld_we;
    logic [3:0]           ld_addr;
    logic [3:0]           ld_data;
    logic                 ld_commit;
    logic [7:0]           tbl_gen;

    modport master (
        output in_valid, in_data, out_ready, ld_we, ld_addr, ld_data, ld_commit,
        input  in_ready, out_valid, out_data, tbl_gen
    );

    modport slave (
        input  in_valid, in_data, out_ready, ld_we, ld_addr, ld_data, ld_commit,
        output in_ready, out_valid, out_data, tbl_gen
    );
endinterface

// File: rtl/sbox_bank.sv
// Multi-lane programmable 4-bit S-box: two-stage valid/ready pipeline over a shared
// active table, with a shadow table that is committed atomically.
module sbox_bank #(
    parameter int unsigned LANES = 8
) (
    input logic        ck,
    input logic        rst,
    sbox_bank_if.slave bus
);
    localparam int unsigned W = 4 * LANES;

    function automatic logic [3:0] default_map(input logic [3:0] idx);
        logic [3:0] r;
        case (idx)
            4'd0:  r = 4'd14;
            4'd1:  r = 4'd4;
            4'd2:  r = 4'd13;
            4'd3:  r = 4'd14;
            4'd4:  r = 4'd4;
            4'd5:  r = 4'd1;
            4'd6:  r = 4'd1;
            4'd7:  r = 4'd8;
            4'd8:  r = 4'd0;
            4'd9:  r = 4'd15;
            4'd10: r = 4'd7;
            4'd11: r = 4'd8;
            4'd12: r = 4'd15;
            4'd13: r = 4'd12;
            4'd14: r = 4'd4;
            4'd15: r = 4'd2;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    logic [3:0]   active [16];
    logic [3:0]   shadow [16];
    logic         v1_q;
    logic         v2_q;
    logic [W-1:0] d1_q;
    logic [W-1:0] d2_q;
    logic [7:0]   gen_q;
    logic [W-1:0] sub_data;
    logic         s2_load;
    logic         ready;
    logic         accept;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    always_comb begin
        s2_load = !v2_q || bus.out_ready;
        ready   = !v1_q || s2_load;
        accept  = bus.in_valid && ready;
    end

    always_comb begin
        sub_data = '0;
        for (int k = 0; k < LANES; k++) begin
            sub_data[4*k +: 4] = active[bus.in_data[4*k +: 4]];
        end
    end

    always_comb begin
        bus.in_ready  = ready;
        bus.out_valid = v2_q;
        bus.out_data  = d2_q;
        bus.tbl_gen   = gen_q;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            d1_q  <= '0;
            d2_q  <= '0;
            gen_q <= 8'd0;
            for (int i = 0; i < 16; i++) begin
                active[i] <= default_map(4'(i));
                shadow[i] <= default_map(4'(i));
            end
        end else begin
            if (s2_load) begin
                v2_q <= v1_q;
                d2_q <= d1_q;
            end
            if (accept) begin
                v1_q <= 1'b1;
                d1_q <= sub_data;
            end else if (s2_load) begin
                v1_q <= 1'b0;
            end
            // Non-blocking update: commit copies the shadow as it was before any same-cycle write.
            if (bus.ld_commit) begin
                for (int i = 0; i < 16; i++) begin
                    active[i] <= shadow[i];
                end
                gen_q <= gen_q + 8'd1;
            end
            if (bus.ld_we) begin
                shadow[bus.ld_addr] <= bus.ld_data;
            end
        end
    end
endmodule
